// File: rtl/nios_seven_seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nios_seven_seg_pkg : register map, CTRL fields and hex segment table  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package nios_seven_seg_pkg;

  localparam logic [3:0] ADDR_VALUE     = 4'd0;
  localparam logic [3:0] ADDR_CTRL      = 4'd1;
  localparam logic [3:0] ADDR_BLINK_DIV = 4'd2;
  localparam logic [3:0] ADDR_STATUS    = 4'd3;
  localparam logic [3:0] ADDR_RAW0      = 4'd4;

  localparam int CTRL_RAW_MODE_BIT = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_BLANK_LSB    = 8;
  localparam int CTRL_BLINK_LSB    = 24;

  // Active-high segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seven_seg_hex_decoder : combinational nibble to active-high segments  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seven_seg_hex_decoder
  import nios_seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/nios_seven_seg_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nios_seven_seg_ctrl : Avalon-MM seven-segment controller with blink   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nios_seven_seg_ctrl
  import nios_seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int CNT_W          = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port
);

  localparam logic                    POL     = (SEG_ACTIVE_LOW != 0);
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {(7*NUM_DIGITS){POL}};

  logic [4*NUM_DIGITS-1:0] value;
  logic                    raw_mode;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [CNT_W-1:0]        blink_div;
  logic [CNT_W-1:0]        cnt;
  logic                    phase;
  logic [6:0]              raw [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_next;

  logic wr_en;
  logic restart;
  logic blink_run;
  logic unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign restart   = wr_en & ((address == ADDR_BLINK_DIV) |
                              ((address == ADDR_CTRL) & ~writedata[CTRL_BLINK_EN_BIT]));
  assign blink_run = blink_en & (blink_div != '0);
  assign unused_wd = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value      <= '0;
      raw_mode   <= 1'b0;
      blink_en   <= 1'b0;
      blank      <= '1;
      blink_mask <= '0;
      blink_div  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) raw[i] <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_VALUE: value <= writedata[4*NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          raw_mode   <= writedata[CTRL_RAW_MODE_BIT];
          blink_en   <= writedata[CTRL_BLINK_EN_BIT];
          blank      <= writedata[CTRL_BLANK_LSB +: NUM_DIGITS];
          blink_mask <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
        end
        ADDR_BLINK_DIV: blink_div <= writedata[CNT_W-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (address == 4'(ADDR_RAW0 + i)) raw[i] <= writedata[6:0];
        end
      endcase
    end
  end

  // Prescaler decisions use the pre-write enable/divider; restarting writes win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart || !blink_run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt >= blink_div) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] hex_seg;
    logic       force_off;

    seven_seg_hex_decoder u_dec (
      .nibble (value[4*g +: 4]),
      .seg    (hex_seg)
    );

    assign force_off           = blank[g] | (blink_en & phase & blink_mask[g]);
    assign seg_next[7*g +: 7]  = force_off ? 7'h00 : (raw_mode ? raw[g] : hex_seg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= SEG_OFF;
    else          out_port <= seg_next ^ SEG_OFF;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_VALUE: readdata[4*NUM_DIGITS-1:0] = value;
      ADDR_CTRL: begin
        readdata[CTRL_RAW_MODE_BIT]             = raw_mode;
        readdata[CTRL_BLINK_EN_BIT]             = blink_en;
        readdata[CTRL_BLANK_LSB +: NUM_DIGITS]  = blank;
        readdata[CTRL_BLINK_LSB +: NUM_DIGITS]  = blink_mask;
      end
      ADDR_BLINK_DIV: readdata[CNT_W-1:0] = blink_div;
      ADDR_STATUS:    readdata[0]         = phase;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (address == 4'(ADDR_RAW0 + i)) readdata[6:0] = raw[i];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_seven_seg_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nios_seven_seg_ctrl : directed + random bench with reference model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_nios_seven_seg_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [27:0] out_port;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  nios_seven_seg_ctrl #(
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1),
    .CNT_W          (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: registers as plain variables, blink phase derived from elapsed ticks.
  logic [15:0] m_value;
  logic        m_raw_mode, m_en;
  logic [3:0]  m_blank, m_blinkm;
  int          m_div;
  int          m_t;
  logic [6:0]  m_raw [4];
  logic [27:0] m_out;
  logic [27:0] m_nxt;
  bit          m_wr;

  function automatic bit m_phase();
    return ((m_t / (m_div + 1)) % 2) == 1;
  endfunction

  function automatic logic [27:0] model_seg();
    logic [27:0] r;
    logic [6:0]  s;
    for (int i = 0; i < 4; i++) begin
      s = m_raw_mode ? m_raw[i] : HEX[(m_value >> (4*i)) & 16'hF];
      if (m_blank[i] || (m_en && m_phase() && m_blinkm[i])) s = 7'h00;
      r[7*i +: 7] = s ^ 7'h7F;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return {16'h0, m_value};
      4'd1: return {4'h0, m_blinkm, 12'h0, m_blank, 6'h0, m_en, m_raw_mode};
      4'd2: return 32'(m_div);
      4'd3: return {31'h0, m_phase()};
      4'd4, 4'd5, 4'd6, 4'd7: return {25'h0, m_raw[a - 4'd4]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_value = '0; m_raw_mode = 0; m_en = 0; m_blank = 4'hF; m_blinkm = '0;
    m_div = 0; m_t = 0; m_out = 28'hFFFFFFF;
    for (int i = 0; i < 4; i++) m_raw[i] = '0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      m_nxt = model_seg();
      m_wr  = chipselect && !write_n;
      if ((m_wr && (address == 4'd2 || (address == 4'd1 && !writedata[1]))) || !m_en || m_div == 0)
        m_t = 0;
      else
        m_t++;
      if (m_wr) begin
        case (address)
          4'd0: m_value = writedata[15:0];
          4'd1: begin
            m_raw_mode = writedata[0]; m_en = writedata[1];
            m_blank = writedata[11:8]; m_blinkm = writedata[27:24];
          end
          4'd2: m_div = int'(writedata[23:0]);
          4'd4, 4'd5, 4'd6, 4'd7: m_raw[address - 4'd4] = writedata[6:0];
          default: ;
        endcase
      end
      m_out = m_nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_port", {4'h0, out_port}, {4'h0, m_out});
      check("readdata", readdata, model_read(address));
    end
  end

  // Drivers assume the caller sits 1ns after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; chipselect = 1; write_n = 0; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1; writedata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    address = a; chipselect = 1; write_n = 1;
    #2 check(name, readdata, exp);
    chipselect = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_on = 1'b1;
    cycles(2);

    // Defaults after reset
    check("reset_out", {4'h0, out_port}, 32'h0FFFFFFF);
    rd_chk("reset_ctrl", 4'd1, 32'h0000_0F00);

    // Hex mode
    wr(4'd1, 32'h0);
    wr(4'd0, 32'h1A3F);
    cycles(1);
    check("hex_digits", {4'h0, out_port}, {4'h0, ~7'h06, ~7'h77, ~7'h4F, ~7'h71});
    rd_chk("read_value", 4'd0, 32'h0000_1A3F);

    // Raw mode
    wr(4'd6, 32'h49);
    wr(4'd1, 32'h1);
    cycles(1);
    check("raw_digits", {4'h0, out_port}, {4'h0, 7'h7F, ~7'h49, 7'h7F, 7'h7F});
    rd_chk("read_unmapped", 4'd8, 32'h0);

    // Blink digit 0 with half-period 4
    wr(4'd2, 32'd3);
    wr(4'd1, 32'h0100_0002);
    rd_chk("blink_ph0", 4'd3, 32'h0);
    cycles(3);
    rd_chk("blink_ph0_t3", 4'd3, 32'h0);
    cycles(1);
    rd_chk("blink_ph1_t4", 4'd3, 32'h1);
    cycles(1);
    check("blink_digit0_off", {4'h0, out_port}, {4'h0, ~7'h06, ~7'h77, ~7'h4F, 7'h7F});
    cycles(3);
    rd_chk("blink_ph0_t8", 4'd3, 32'h0);

    // Rewriting the divider restarts the half-period
    cycles(2);
    wr(4'd2, 32'd5);
    rd_chk("div5_clear", 4'd3, 32'h0);
    cycles(5);
    rd_chk("div5_t5", 4'd3, 32'h0);
    cycles(1);
    rd_chk("div5_t6", 4'd3, 32'h1);
    wr(4'd2, 32'd0);
    cycles(10);
    rd_chk("div0_frozen", 4'd3, 32'h0);

    // Asynchronous reset mid-blink
    wr(4'd2, 32'd2);
    wr(4'd1, 32'h0F00_0002);
    cycles(7);
    #2 reset_n = 1'b0;
    #1 check("async_rst_out", {4'h0, out_port}, 32'h0FFFFFFF);
    rd_chk("async_rst_status", 4'd3, 32'h0);
    rd_chk("async_rst_ctrl", 4'd1, 32'h0000_0F00);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      address    = 4'($urandom_range(0, 9));
      chipselect = ($urandom % 4) != 0;
      write_n    = ($urandom % 3) != 0;
      writedata  = $urandom;
      if (address == 4'd2) writedata = 32'($urandom_range(0, 6));
      if (address == 4'd1 && ($urandom % 4) != 0) writedata[1] = 1'b1;
      @(posedge clk); #1;
    end
    chipselect = 0; write_n = 1;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
